// File: rtl/gemm_feeder_pkg.sv
// Shared types and default sizing for the GEMM tile feeder.
//   state_e : sequencer states
//   tile_t  : packed tile as delivered by the operand read ports (default sizing)
package gemm_feeder_pkg;

   localparam int unsigned InDataWidthDef = 8;
   localparam int unsigned SqDimDef       = 4;
   localparam int unsigned AddrWidthDef   = 16;
   localparam int unsigned KWidthDef      = 16;
   localparam int unsigned MacLatencyDef  = 1;

   localparam int unsigned TileBits = SqDimDef * SqDimDef * InDataWidthDef;

   typedef logic [TileBits-1:0] tile_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ISSUE,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/feeder_fetch_pipe.sv
// Req-to-valid delay line and unpack registers for one operand port.
//   clk, rst : clock, synchronous active-high reset
//   req      : read request issued this cycle (rdata arrives next cycle)
//   rdata    : tile-wide read data
//   pend     : a read is in flight (rdata is valid this cycle)
//   valid    : unpacked tile on data is a valid beat
//   data     : unpacked signed tile, holds its value between beats
module feeder_fetch_pipe #(
   parameter int unsigned InDataWidth = 8,
   parameter int unsigned sqDim       = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req,
   input  logic [sqDim*sqDim*InDataWidth-1:0]  rdata,
   output logic                                pend,
   output logic                                valid,
   output logic signed [InDataWidth-1:0]       data [sqDim][sqDim]
);

   // Capture rdata the cycle after req; present it one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend  <= 1'b0;
         valid <= 1'b0;
         for (int r = 0; r < int'(sqDim); r++) begin
            for (int c = 0; c < int'(sqDim); c++) begin
               data[r][c] <= '0;
            end
         end
      end else begin
         pend  <= req;
         valid <= pend;
         if (pend) begin
            for (int r = 0; r < int'(sqDim); r++) begin
               for (int c = 0; c < int'(sqDim); c++) begin
                  data[r][c] <= rdata[(r*int'(sqDim)+c)*int'(InDataWidth) +: InDataWidth];
               end
            end
         end
      end
   end

endmodule

// File: rtl/gemm_tile_feeder.sv
// Operand sequencer for the tile MAC array: walks K, fetches A/B tiles,
// and streams unpacked operand beats with init_save/acc_clr/done framing.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i + config inputs : job launch (config latched on accept)
//   hold_i                  : suppresses new fetches while high
//   a_/b_ req/addr/rdata    : tile read ports, 1-cycle read latency
//   a_/b_ data/valid        : operand beats to the array
//   init_save_o, acc_clr_o  : first-beat marker, accumulator clear pulse
//   busy_o, done_o          : job in progress, completion pulse
//   MacLatency must be at least 1.
module gemm_tile_feeder
   import gemm_feeder_pkg::*;
#(
   parameter int unsigned InDataWidth = InDataWidthDef,
   parameter int unsigned sqDim       = SqDimDef,
   parameter int unsigned AddrWidth   = AddrWidthDef,
   parameter int unsigned KWidth      = KWidthDef,
   parameter int unsigned MacLatency  = MacLatencyDef
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   input  logic [KWidth-1:0]                   k_tiles_i,
   input  logic [AddrWidth-1:0]                a_base_i,
   input  logic [AddrWidth-1:0]                b_base_i,
   input  logic [AddrWidth-1:0]                a_stride_i,
   input  logic [AddrWidth-1:0]                b_stride_i,
   input  logic                                hold_i,
   output logic                                a_req_o,
   output logic                                b_req_o,
   output logic [AddrWidth-1:0]                a_addr_o,
   output logic [AddrWidth-1:0]                b_addr_o,
   input  logic [sqDim*sqDim*InDataWidth-1:0]  a_rdata_i,
   input  logic [sqDim*sqDim*InDataWidth-1:0]  b_rdata_i,
   output logic signed [InDataWidth-1:0]       a_data_o [sqDim][sqDim],
   output logic signed [InDataWidth-1:0]       b_data_o [sqDim][sqDim],
   output logic                                a_valid_o,
   output logic                                b_valid_o,
   output logic                                init_save_o,
   output logic                                acc_clr_o,
   output logic                                busy_o,
   output logic                                done_o
);

   localparam int unsigned DrainW = (MacLatency > 1) ? $clog2(MacLatency) : 1;

   state_e                 state;
   logic [KWidth-1:0]      k_tiles_q;
   logic [KWidth-1:0]      k_cnt;
   logic [AddrWidth-1:0]   a_ptr;
   logic [AddrWidth-1:0]   b_ptr;
   logic [AddrWidth-1:0]   a_stride_q;
   logic [AddrWidth-1:0]   b_stride_q;
   logic [DrainW-1:0]      drain_cnt;
   logic                   first_beat;
   logic                   a_pend;
   logic                   b_pend;
   logic                   pipe_empty_c;

   // Nothing requested, in flight, or being presented on either port.
   assign pipe_empty_c = !a_req_o && !b_req_o && !a_pend && !b_pend
                         && !a_valid_o && !b_valid_o;

   // Sequencer: state, counters, address walk and framing outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         k_tiles_q   <= '0;
         k_cnt       <= '0;
         a_ptr       <= '0;
         b_ptr       <= '0;
         a_stride_q  <= '0;
         b_stride_q  <= '0;
         drain_cnt   <= '0;
         first_beat  <= 1'b0;
         a_req_o     <= 1'b0;
         b_req_o     <= 1'b0;
         a_addr_o    <= '0;
         b_addr_o    <= '0;
         init_save_o <= 1'b0;
         acc_clr_o   <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         a_req_o   <= 1'b0;
         b_req_o   <= 1'b0;
         acc_clr_o <= 1'b0;
         done_o    <= 1'b0;

         // The first capture of a job becomes the init_save beat next cycle.
         init_save_o <= a_pend && first_beat;
         if (a_pend) first_beat <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start_i) begin
                  k_tiles_q  <= k_tiles_i;
                  a_ptr      <= a_base_i;
                  b_ptr      <= b_base_i;
                  a_stride_q <= a_stride_i;
                  b_stride_q <= b_stride_i;
                  first_beat <= 1'b1;
                  busy_o     <= 1'b1;
                  state      <= CLEAR;
               end
            end
            CLEAR: begin
               acc_clr_o <= 1'b1;
               k_cnt     <= '0;
               drain_cnt <= '0;
               state     <= (k_tiles_q != '0) ? ISSUE : DRAIN;
            end
            ISSUE: begin
               // Running pointer equals base + k_cnt*stride modulo 2^AddrWidth.
               if (!hold_i) begin
                  a_req_o  <= 1'b1;
                  b_req_o  <= 1'b1;
                  a_addr_o <= a_ptr;
                  b_addr_o <= b_ptr;
                  a_ptr    <= a_ptr + a_stride_q;
                  b_ptr    <= b_ptr + b_stride_q;
                  k_cnt    <= k_cnt + KWidth'(1);
                  if (k_cnt == k_tiles_q - KWidth'(1)) state <= DRAIN;
               end
            end
            DRAIN: begin
               // Empty job finishes at once; otherwise wait out the MAC latency.
               if ((k_tiles_q == '0) ||
                   (pipe_empty_c && (drain_cnt == DrainW'(MacLatency - 1)))) begin
                  done_o <= 1'b1;
                  busy_o <= 1'b0;
                  state  <= DONE;
               end else if (pipe_empty_c) begin
                  drain_cnt <= drain_cnt + DrainW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   feeder_fetch_pipe #(
      .InDataWidth (InDataWidth),
      .sqDim       (sqDim)
   ) u_fetch_a (
      .clk   (clk_i),
      .rst   (rst_i),
      .req   (a_req_o),
      .rdata (a_rdata_i),
      .pend  (a_pend),
      .valid (a_valid_o),
      .data  (a_data_o)
   );

   feeder_fetch_pipe #(
      .InDataWidth (InDataWidth),
      .sqDim       (sqDim)
   ) u_fetch_b (
      .clk   (clk_i),
      .rst   (rst_i),
      .req   (b_req_o),
      .rdata (b_rdata_i),
      .pend  (b_pend),
      .valid (b_valid_o),
      .data  (b_data_o)
   );

endmodule

// File: doc/gemm_tile_feeder.md
Name: gemm_tile_feeder

Overview:
Operand-side sequencer for the tile MAC array. On start it walks the K dimension and fetches one A tile and one B tile per K-step from two tile-wide read ports (fixed 1-cycle read latency). It unpacks each tile and drives a_data/b_data with a_valid/b_valid, init_save and acc_clr into the tile MAC array. It signals done once the last product has been accumulated. It is the transmitter for the array's operand inputs and sits between the operand SRAMs/controller and the array.

Parameters:
InDataWidth, 8, operand element width (signed)
sqDim, 4, tile dimension; a tile holds sqDim*sqDim elements
AddrWidth, 16, tile address width of both read ports
KWidth, 16, width of the K-tile count
MacLatency, 1, cycles from the last valid beat until the array accumulator holds the final value

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  start job; sampled only in IDLE
k_tiles_i  in  KWidth  number of K-steps (unsigned); latched on start
a_base_i / b_base_i  in  AddrWidth  first tile address; latched on start
a_stride_i / b_stride_i  in  AddrWidth  address increment per K-step; latched on start
hold_i  in  1  backpressure: while high, no new fetch is issued
a_req_o / b_req_o  out  1  read request
a_addr_o / b_addr_o  out  AddrWidth  read address
a_rdata_i / b_rdata_i  in  sqDim*sqDim*InDataWidth  tile data, valid 1 cycle after req
a_data_o / b_data_o  out  signed InDataWidth [sqDim][sqDim]  unpacked operand tile
a_valid_o / b_valid_o  out  1  operand beat valid (always equal to each other)
init_save_o  out  1  high with the first beat of a job
acc_clr_o  out  1  one-cycle accumulator clear
busy_o  out  1  high from the start-accept cycle until done
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i high at a clock edge): FSM goes to IDLE; all outputs are 0, including the data arrays; counters and the in-flight pipeline are cleared. Reset mid-job aborts the job: no done_o, and no valid beat in the cycle after reset.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE -> CLEAR when start_i is high. The cycle that samples start_i latches the config and sets busy_o. start_i is ignored in every other state.
- CLEAR: acc_clr_o=1 for exactly one cycle; k_cnt=0.
  - Next state is ISSUE if the latched k_tiles is nonzero.
  - Next state is DRAIN if k_tiles==0. In that case no fetches and no valid beats occur, and C stays 0.
- ISSUE, each cycle with hold_i low:
  - a_req_o=b_req_o=1
  - a_addr_o = a_base + k_cnt*a_stride, b_addr_o likewise, both mod 2^AddrWidth (wrap is silent)
  - k_cnt increments
  - after issuing k_cnt==k_tiles-1, next state is DRAIN
- ISSUE with hold_i high: req_o=0 and addresses hold. In-flight data still completes.
- Fetch pipeline:
  - cycle t: req
  - cycle t+1: rdata captured and unpacked into the output registers
  - cycle t+2: a_data_o/b_data_o presented with a_valid_o=b_valid_o=1
  - Beats are in K order with no gaps except those caused by hold.
- Unpack rule: element [r][c] = rdata[(r*sqDim+c)*InDataWidth +: InDataWidth].
- When valid_o is 0, the data outputs hold their previous values.
- init_save_o=1 on the first valid beat of the job only.
- DRAIN: waits until the last beat has left the pipeline, plus MacLatency cycles.
  - Beat-carrying job: done_o rises exactly MacLatency+1 cycles after the last valid beat.
  - k_tiles==0: DRAIN is a single cycle.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, next state is IDLE. A start_i in the DONE cycle is ignored; the earliest accept is the following cycle.
- Job latency with no hold and MacLatency=1: start accept at cycle 0, CLEAR at 1, first req at 2, first valid beat at 4, done_o at 4+k_tiles+1.

Decomposition:
- Package gemm_feeder_pkg:
  - state enum typedef (IDLE, CLEAR, ISSUE, DRAIN, DONE)
  - localparam TileBits = sqDim*sqDim*InDataWidth
  - packed tile typedef
- One sub-module, feeder_fetch_pipe. It owns the req-to-valid delay line and the unpack registers for one operand and is instantiated twice (A, B). The FSM, counters and address generation live in the top module.

Test Plan:
- Reset mid-ISSUE (k_tiles=8, reset at the 3rd req) -> all outputs 0 the next cycle, no done_o; a fresh start afterwards runs normally.
- Identity check: k_tiles=1, A tile = identity, B tile elements 1..16 -> one beat with init_save_o=1, acc_clr_o 3 cycles earlier, b_data_o[r][c]=r*4+c+1, done_o at cycle 6.
- k_tiles=3, a_base=0x10, a_stride=4, b_base=0x100, b_stride=0x20 -> a_addr 0x10,0x14,0x18; b_addr 0x100,0x120,0x140; 3 back-to-back valid beats; init_save only on the first.
- hold_i pattern: k_tiles=4, hold_i high for 2 cycles after the 2nd req -> 4 beats with a 2-cycle gap, order preserved, done_o delayed by 2 cycles.
- k_tiles=0 -> acc_clr_o pulse, zero valid beats, done_o one cycle after DRAIN; start_i pulsed while busy is ignored.
- Address wrap: AddrWidth=16, a_base=0xFFFC, a_stride=4, k_tiles=2 -> a_addr 0xFFFC then 0x0000. Signed data: element 0x80 appears as -128 on a_data_o.
